// File: rtl/core_pkg.sv
// Shared core definitions: register address width, zero register,
// forwarding-select encoding and the in-flight entry record.
package core_pkg;

    localparam int RA_W     = 5;
    localparam int REG_ZERO = 0;

    // Forwarding select encoding: 0 reads the regfile, k+1 takes entry k.
    localparam int FWD_RF   = 0;

    function automatic int unsigned fwd_stage(input int unsigned k);
        return k + 1;
    endfunction

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            is_load;
    } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Priority match of one source register against all in-flight entries;
// the youngest (lowest-index) valid producer wins.
module hazard_match
    import core_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int DEPTH = 2,
    parameter int SEL_W = 2
) (
    input  logic [RA_W-1:0]            src,
    input  logic [DEPTH-1:0]           valid,
    input  logic [DEPTH-1:0][RA_W-1:0] rd,
    output logic [SEL_W-1:0]           sel
);

    logic found;

    // Scan from youngest to oldest and lock onto the first hit.
    always_comb begin
        sel   = SEL_W'(FWD_RF);
        found = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && valid[k] && (rd[k] == src) && (src != RA_W'(REG_ZERO))) begin
                sel   = SEL_W'(fwd_stage(k));
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: tracks destinations of DEPTH post-decode stages, drives
// per-operand forwarding selects, a load-use stall, and stall/flush counters.
module hazard_unit
    import core_pkg::*;
#(
    parameter  int RA_W  = core_pkg::RA_W,
    parameter  int DEPTH = 2,
    parameter  int CNT_W = 16,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_rs1,
    output logic [SEL_W-1:0] fwd_rs2,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Local record sized by this instance's RA_W (the package record uses the core default).
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            is_load;
    } stage_t;

    stage_t                     entries [DEPTH];
    logic [DEPTH-1:0]           valid_vec;
    logic [DEPTH-1:0][RA_W-1:0] rd_vec;
    logic                       load_hit;

    // Flatten the entry array for the match units.
    always_comb begin
        valid_vec = '0;
        rd_vec    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            valid_vec[k] = entries[k].valid;
            rd_vec[k]    = entries[k].rd;
        end
    end

    hazard_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs1 (
        .src   (id_rs1),
        .valid (valid_vec),
        .rd    (rd_vec),
        .sel   (fwd_rs1)
    );

    hazard_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs2 (
        .src   (id_rs2),
        .valid (valid_vec),
        .rd    (rd_vec),
        .sel   (fwd_rs2)
    );

    // Load-use: a load in EX whose result a decoding source needs; flush overrides.
    always_comb begin
        load_hit = entries[0].valid && entries[0].is_load && (entries[0].rd != '0)
                   && ((entries[0].rd == id_rs1) || (entries[0].rd == id_rs2));
        stall    = id_valid && !flush && load_hit;
    end

    // Shift the in-flight pipeline every cycle; stall or flush injects a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
        end else begin
            entries[0].valid   <= id_valid && id_rd_we && (id_rd != '0) && !stall && !flush;
            entries[0].rd      <= id_rd;
            entries[0].is_load <= id_is_load;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: a default instance (DEPTH=2, CNT_W=16)
// and a small instance (DEPTH=1, CNT_W=2) driven with the same stimulus.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rd_we, id_is_load, flush;

    logic [1:0]  fwd_rs1, fwd_rs2;
    logic        stall;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_fwd_rs1, s_fwd_rs2, s_stall;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.RA_W(5), .DEPTH(1), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
        .fwd_rs1(s_fwd_rs1), .fwd_rs2(s_fwd_rs2), .stall(s_stall),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Apply a decode-stage instruction and let combinational outputs settle.
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_we = we; id_is_load = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (fwd_rs1 !== 2'd0 || fwd_rs2 !== 2'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL reset_outputs: fwd1=%0d fwd2=%0d stall=%0b expected 0 0 0", fwd_rs1, fwd_rs2, stall); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_counters: stall_cnt=%0d flush_cnt=%0d expected 0 0", stall_cnt, flush_cnt); end
        checks++; if (s_stall_cnt !== 2'd0 || s_flush_cnt !== 2'd0 || s_stall !== 1'b0) begin
            failures++; $display("FAIL reset_small: stall_cnt=%0d flush_cnt=%0d stall=%0b expected 0 0 0", s_stall_cnt, s_flush_cnt, s_stall); end
    endtask

    task automatic test_alu_chain();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        checks++; if (fwd_rs1 !== 2'd0) begin
            failures++; $display("FAIL alu_empty: fwd_rs1=%0d expected 0", fwd_rs1); end
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        checks++; if (fwd_rs1 !== 2'd1 || stall !== 1'b0) begin
            failures++; $display("FAIL alu_dist1: fwd_rs1=%0d stall=%0b expected 1 0", fwd_rs1, stall); end
        checks++; if (s_fwd_rs1 !== 1'b1) begin
            failures++; $display("FAIL alu_dist1_small: fwd_rs1=%0d expected 1", s_fwd_rs1); end
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (fwd_rs1 !== 2'd2) begin
            failures++; $display("FAIL alu_dist2: fwd_rs1=%0d expected 2", fwd_rs1); end
        checks++; if (s_fwd_rs1 !== 1'b0) begin
            failures++; $display("FAIL alu_dist2_small: fwd_rs1=%0d expected 0", s_fwd_rs1); end
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (fwd_rs1 !== 2'd0) begin
            failures++; $display("FAIL alu_dist3: fwd_rs1=%0d expected 0", fwd_rs1); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        checks++; if (stall !== 1'b0) begin
            failures++; $display("FAIL load_issue: stall=%0b expected 0", stall); end
        tick();
        set_id(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1 || fwd_rs2 !== 2'd1 || s_stall !== 1'b1) begin
            failures++; $display("FAIL load_use_stall: stall=%0b fwd_rs2=%0d small_stall=%0b expected 1 1 1", stall, fwd_rs2, s_stall); end
        tick();
        checks++; if (stall !== 1'b0 || fwd_rs2 !== 2'd2 || stall_cnt !== 16'd1) begin
            failures++; $display("FAIL load_use_after: stall=%0b fwd_rs2=%0d stall_cnt=%0d expected 0 2 1", stall, fwd_rs2, stall_cnt); end
        checks++; if (s_stall !== 1'b0 || s_fwd_rs2 !== 1'b0 || s_stall_cnt !== 2'd1) begin
            failures++; $display("FAIL load_use_after_small: stall=%0b fwd_rs2=%0d stall_cnt=%0d expected 0 0 1", s_stall, s_fwd_rs2, s_stall_cnt); end
        drain();
    endtask

    task automatic test_youngest_wins();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0);
        checks++; if (fwd_rs1 !== 2'd1) begin
            failures++; $display("FAIL youngest_single: fwd_rs1=%0d expected 1", fwd_rs1); end
        tick();
        set_id(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
        checks++; if (fwd_rs1 !== 2'd1 || fwd_rs2 !== 2'd1) begin
            failures++; $display("FAIL youngest_both: fwd_rs1=%0d fwd_rs2=%0d expected 1 1", fwd_rs1, fwd_rs2); end
        drain();
    endtask

    task automatic test_reg_zero();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        checks++; if (fwd_rs1 !== 2'd0 || fwd_rs2 !== 2'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL zero_alu: fwd1=%0d fwd2=%0d stall=%0b expected 0 0 0", fwd_rs1, fwd_rs2, stall); end
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_rs1 !== 2'd0 || s_stall !== 1'b0) begin
            failures++; $display("FAIL zero_load: stall=%0b fwd1=%0d small_stall=%0b expected 0 0 0", stall, fwd_rs1, s_stall); end
        drain();
        checks++; if (stall_cnt !== 16'd1) begin
            failures++; $display("FAIL zero_stall_cnt: stall_cnt=%0d expected 1", stall_cnt); end
    endtask

    task automatic test_flush_load_use();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_id(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0 || s_stall !== 1'b0) begin
            failures++; $display("FAIL flush_stall: stall=%0b small_stall=%0b expected 0 0", stall, s_stall); end
        tick();
        flush = 1'b0;
        set_id(1'b1, 5'd9, 5'd10, 5'd0, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_rs1 !== 2'd2 || fwd_rs2 !== 2'd0) begin
            failures++; $display("FAIL flush_bubble: stall=%0b fwd1=%0d fwd2=%0d expected 0 2 0", stall, fwd_rs1, fwd_rs2); end
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
            failures++; $display("FAIL flush_counters: flush_cnt=%0d stall_cnt=%0d expected 1 1", flush_cnt, stall_cnt); end
        checks++; if (s_flush_cnt !== 2'd1 || s_stall_cnt !== 2'd1 || s_fwd_rs2 !== 1'b0) begin
            failures++; $display("FAIL flush_small: flush_cnt=%0d stall_cnt=%0d fwd2=%0d expected 1 1 0", s_flush_cnt, s_stall_cnt, s_fwd_rs2); end
        drain();
    endtask

    task automatic test_reset_and_saturation();
        logic exp_stall;
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1) begin
            failures++; $display("FAIL pre_reset_stall: stall=%0b expected 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || fwd_rs1 !== 2'd0 || fwd_rs2 !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++; $display("FAIL mid_stall_reset: stall=%0b fwd1=%0d fwd2=%0d scnt=%0d fcnt=%0d expected all 0", stall, fwd_rs1, fwd_rs2, stall_cnt, flush_cnt); end
        // A load reading its own destination stalls every other cycle.
        set_id(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp_stall = (i % 2 == 1);
            checks++; if (stall !== exp_stall || s_stall !== exp_stall) begin
                failures++; $display("FAIL sat_stall_%0d: stall=%0b small_stall=%0b expected %0b", i, stall, s_stall, exp_stall); end
            tick();
        end
        checks++; if (stall_cnt !== 16'd5) begin
            failures++; $display("FAIL sat_main_cnt: stall_cnt=%0d expected 5", stall_cnt); end
        checks++; if (s_stall_cnt !== 2'd3) begin
            failures++; $display("FAIL sat_small_cnt: stall_cnt=%0d expected 3", s_stall_cnt); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest_wins();
        test_reg_zero();
        test_flush_load_use();
        test_reset_and_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
